// File: rtl/marlann_cmd_seq_if.sv
// marlann_cmd_seq_if
// Host byte stream plus memory write bus for the command sequencer.
//   frame_start / frame_end : one-cycle frame delimiters from the host link
//   din_valid / din_data    : received byte strobe and byte
//   mem_we / mem_addr / mem_wdata : one-cycle write to the model memory
// The slave modport is the sequencer side; the master modport is the
// host/memory side (testbench or surrounding SoC).
interface marlann_cmd_seq_if #(
  parameter int ADDR_BITS = 16
);
  logic                 frame_start;
  logic                 frame_end;
  logic                 din_valid;
  logic [7:0]           din_data;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;

  modport master (
    output frame_start,
    output frame_end,
    output din_valid,
    output din_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  frame_start,
    input  frame_end,
    input  din_valid,
    input  din_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/marlann_cmd_seq.sv
// marlann_cmd_seq
// Decodes host command frames into memory writes, an engine start pulse
// and a debug LED load.
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high
//   bus        : marlann_cmd_seq_if.slave (byte stream in, memory write out)
//   exec_busy  : compute engine running
//   exec_start : one-cycle engine start pulse
//   leds       : debug LED register
//   ml_rdy     : registered ready flag (engine idle, no start in flight)
//   ml_err     : sticky error flag, cleared by frame_start or reset
// Build option: define MARLANN_LEDCMD_EN to enable the 0x23 LED command;
// without it 0x23 is an unknown command and leds stays at 0.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | outside a frame, bytes ignored
// CMD       | waiting for the command byte
// ADDR_HI   | waiting for address bits [15:8]
// ADDR_LO   | waiting for address bits [7:0]
// WDATA     | every byte is written, address post-increments
// LED       | next byte loads the LED register
// DISCARD   | rest of frame ignored
module marlann_cmd_seq #(
  parameter int ADDR_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  marlann_cmd_seq_if.slave        bus,
  input  logic                    exec_busy,
  output logic                    exec_start,
  output logic [4:0]              leds,
  output logic                    ml_rdy,
  output logic                    ml_err
);

  localparam logic [7:0] CMD_WRITE = 8'h21;
  localparam logic [7:0] CMD_EXEC  = 8'h22;
  localparam logic [7:0] CMD_LED   = 8'h23;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, LED, DISCARD
  } state_t;

  state_t               state_q, state_n;
  logic [ADDR_BITS-1:0] addr_q, addr_n;
  logic [15:0]          addr_wide, addr_hi_ld, addr_lo_ld;

  logic byte_ok;
  logic we_n;
  logic start_n;
  logic err_set;
  logic err_clr;

  // A byte only counts when no frame delimiter arrives in the same cycle.
  assign byte_ok = bus.din_valid && !bus.frame_start && !bus.frame_end;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    if (bus.frame_start) begin
      state_n = CMD;
    end else if (bus.frame_end) begin
      state_n = IDLE;
    end else if (bus.din_valid) begin
      unique case (state_q)
        CMD: begin
          if (bus.din_data == CMD_WRITE)     state_n = ADDR_HI;
`ifdef MARLANN_LEDCMD_EN
          else if (bus.din_data == CMD_LED)  state_n = LED;
`endif
          else                               state_n = DISCARD;
        end
        ADDR_HI: state_n = ADDR_LO;
        ADDR_LO: state_n = WDATA;
        WDATA:   state_n = WDATA;
        LED:     state_n = DISCARD;
        default: state_n = state_q;
      endcase
    end
  end

  // Address load paths; upper bits beyond ADDR_BITS fall off when truncated.
  always_comb begin
    addr_wide  = 16'(addr_q);
    addr_hi_ld = {bus.din_data, addr_wide[7:0]};
    addr_lo_ld = {addr_wide[15:8], bus.din_data};
  end

  // Output / datapath control
  always_comb begin
    we_n    = 1'b0;
    start_n = 1'b0;
    err_set = 1'b0;
    err_clr = bus.frame_start;
    addr_n  = addr_q;
    if (!bus.frame_start && bus.frame_end &&
        (state_q == ADDR_HI || state_q == ADDR_LO)) begin
      err_set = 1'b1;
    end
    if (byte_ok) begin
      unique case (state_q)
        CMD: begin
          if (bus.din_data == CMD_EXEC) begin
            if (exec_busy) err_set = 1'b1;
            else           start_n = 1'b1;
          end else if (bus.din_data != CMD_WRITE
`ifdef MARLANN_LEDCMD_EN
                       && bus.din_data != CMD_LED
`endif
                      ) begin
            err_set = 1'b1;
          end
        end
        ADDR_HI: addr_n = addr_hi_ld[ADDR_BITS-1:0];
        ADDR_LO: addr_n = addr_lo_ld[ADDR_BITS-1:0];
        WDATA: begin
          we_n   = 1'b1;
          addr_n = addr_q + ADDR_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q        <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'h00;
      exec_start    <= 1'b0;
      ml_rdy        <= 1'b0;
      ml_err        <= 1'b0;
    end else begin
      addr_q     <= addr_n;
      bus.mem_we <= we_n;
      if (we_n) begin
        bus.mem_addr  <= addr_q;
        bus.mem_wdata <= bus.din_data;
      end
      exec_start <= start_n;
      // Held low while a start is being issued and for the pulse cycle,
      // giving the engine a cycle to raise exec_busy.
      ml_rdy <= !exec_busy && !start_n && !exec_start;
      if (err_clr)      ml_err <= 1'b0;
      else if (err_set) ml_err <= 1'b1;
    end
  end

`ifdef MARLANN_LEDCMD_EN
  logic       led_load;
  logic [4:0] leds_q;

  assign led_load = byte_ok && (state_q == LED);

  always_ff @(posedge clock) begin
    if (reset)         leds_q <= 5'd0;
    else if (led_load) leds_q <= bus.din_data[4:0];
  end

  assign leds = leds_q;
`else
  assign leds = 5'd0;
`endif

endmodule

// File: tb/tb_marlann_cmd_seq.sv
module tb_marlann_cmd_seq;
  logic       clock = 1'b0;
  logic       reset;
  logic       exec_busy;
  logic       exec_start;
  logic [4:0] leds;
  logic       ml_rdy;
  logic       ml_err;

  int errors = 0;
  int checks = 0;

  logic [23:0] wq[$];   // expected writes {addr, data}
  int          sq[$];   // expected exec_start pulses

  marlann_cmd_seq_if #(.ADDR_BITS(16)) bus ();

  marlann_cmd_seq #(.ADDR_BITS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .exec_busy  (exec_busy),
    .exec_start (exec_start),
    .leds       (leds),
    .ml_rdy     (ml_rdy),
    .ml_err     (ml_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or start.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [23:0] e;
        e = wq.pop_front();
        chk("mem_write", {8'h00, bus.mem_addr, bus.mem_wdata}, {8'h00, e});
      end
    end
    if (exec_start === 1'b1) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_exec_start: got 1 expected 0");
      end else begin
        int tag;
        tag = sq.pop_front();
        chk("exec_start", 32'(tag), 32'(tag));
      end
    end
  end

  // Drive for one cycle: inputs set #1 after an edge, sampled at the next.
  task automatic step(input logic fs, input logic fe, input logic dv, input logic [7:0] d);
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.din_valid   = dv;
    bus.din_data    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fstart();
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fend();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b0, 1'b1, b);
  endtask

  initial begin
    reset = 1'b1;
    exec_busy = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end = 1'b0;
    bus.din_valid = 1'b0;
    bus.din_data = 8'h00;
    @(posedge clock); #1;
    idle(); idle();
    chk("reset_outputs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, exec_start, leds, ml_rdy, ml_err}, 32'h0);

    reset = 1'b0;
    idle();
    chk("ml_rdy_after_reset", ml_rdy, 1);

    // Basic write frame
    wq.push_back({16'h1234, 8'hAA});
    wq.push_back({16'h1235, 8'hBB});
    fstart();
    send(8'h21); send(8'h12); send(8'h34); send(8'hAA); send(8'hBB);
    fend(); idle(); idle();
    chk("ml_err_write_frame", ml_err, 0);

    // Address wrap
    wq.push_back({16'hFFFF, 8'h01});
    wq.push_back({16'h0000, 8'h02});
    fstart();
    send(8'h21); send(8'hFF); send(8'hFF); send(8'h01); send(8'h02);
    fend(); idle(); idle();

    // Engine start with idle engine
    sq.push_back(1);
    fstart();
    send(8'h22);
    chk("exec_start_pulse", exec_start, 1);
    chk("ml_rdy_during_start", ml_rdy, 0);
    idle();
    chk("exec_start_single", exec_start, 0);
    idle();
    chk("ml_rdy_recovers", ml_rdy, 1);
    chk("ml_err_exec_ok", ml_err, 0);
    fend();

    // Engine start while busy
    exec_busy = 1'b1;
    idle();
    chk("ml_rdy_busy", ml_rdy, 0);
    fstart();
    send(8'h22); idle();
    chk("ml_err_exec_busy", ml_err, 1);
    fend(); idle();
    chk("ml_err_sticky", ml_err, 1);
    fstart();
    chk("ml_err_cleared", ml_err, 0);
    fend();
    exec_busy = 1'b0;
    idle(); idle();

    // Truncated address frame
    fstart();
    send(8'h21); send(8'h12);
    fend();
    chk("ml_err_trunc_addr", ml_err, 1);
    send(8'h5A); send(8'h6B); idle();
    chk("ml_err_after_idle_bytes", ml_err, 1);

    // LED command
    fstart();
    send(8'h23); send(8'h1F); idle();
`ifdef MARLANN_LEDCMD_EN
    chk("leds_loaded", leds, 5'h1F);
    chk("ml_err_led", ml_err, 0);
`else
    chk("leds_held", leds, 5'h00);
    chk("ml_err_led_unknown", ml_err, 1);
`endif
    send(8'h21); send(8'h00); idle();
    fend();

    // Unknown command, rest of frame discarded
    fstart();
    send(8'h55); send(8'h21); send(8'h00); send(8'h00); send(8'h77); idle();
    chk("ml_err_unknown", ml_err, 1);
    fend();

    // frame_start wins over frame_end and a coincident byte
    wq.push_back({16'h0020, 8'hC3});
    fstart();
    send(8'h21); send(8'h00); send(8'h10);
    step(1'b1, 1'b1, 1'b1, 8'h21);
    chk("ml_err_start_wins", ml_err, 0);
    send(8'h21); send(8'h00); send(8'h20); send(8'hC3);
    fend(); idle();
    chk("ml_err_after_override", ml_err, 0);

    // Reset mid-frame
    fstart();
    send(8'h21); send(8'h12); send(8'h34);
    reset = 1'b1;
    idle();
    chk("mid_reset_outputs", {bus.mem_we, bus.mem_addr, bus.mem_wdata, exec_start, leds, ml_rdy, ml_err}, 32'h0);
    reset = 1'b0;
    send(8'h77); send(8'h88); idle(); idle();

    chk("writes_all_seen", 32'(wq.size()), 0);
    chk("starts_all_seen", 32'(sq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end
endmodule

// File: doc/marlann_cmd_seq.md
MARLANN_CMD_SEQ -- requirements
Module: marlann_cmd_seq

Interface
REQ-001 Parameter ADDR_BITS, default 16, meaning: memory address width; legal range 8..16.
REQ-002 clock  in  1  sole clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 frame_start  in  1  one-cycle pulse at host chip-select assertion (already synchronised).
REQ-005 frame_end  in  1  one-cycle pulse at host chip-select deassertion.
REQ-006 din_valid  in  1  one-cycle strobe: din_data holds a received byte.
REQ-007 din_data  in  8  received byte, MSB first on wire.
REQ-008 exec_busy  in  1  compute engine running.
REQ-009 mem_we  out  1  one-cycle memory write strobe.
REQ-010 mem_addr  out  ADDR_BITS  write address, valid when mem_we=1.
REQ-011 mem_wdata  out  8  write data, valid when mem_we=1.
REQ-012 exec_start  out  1  one-cycle engine start pulse.
REQ-013 leds  out  5  debug LED register.
REQ-014 ml_rdy  out  1  host-visible ready flag.
REQ-015 ml_err  out  1  host-visible sticky error flag.

Function
REQ-016 FSM states SHALL be IDLE, CMD, ADDR_HI, ADDR_LO, WDATA, LED, DISCARD.
REQ-017 frame_start SHALL force CMD from any state and clear ml_err; a din_valid in that cycle is ignored.
REQ-018 frame_end SHALL force IDLE from any state; if frame_start coincides, frame_start wins.
REQ-019 CMD, byte 0x21 -> ADDR_HI; 0x22 -> DISCARD with exec_start pulsed next cycle if exec_busy=0, else ml_err set, no pulse; 0x23 -> LED; any other byte -> ml_err set, DISCARD.
REQ-020 ADDR_HI byte SHALL load address bits [15:8] (bits above ADDR_BITS-1 dropped) -> ADDR_LO; ADDR_LO byte loads bits [7:0] -> WDATA.
REQ-021 frame_end while in ADDR_HI or ADDR_LO SHALL set ml_err; no write occurs.
REQ-022 WDATA, each byte SHALL produce mem_we=1 exactly one cycle after din_valid, with mem_addr = current address and mem_wdata = byte.
REQ-023 Address SHALL post-increment per write, wrapping modulo 2^ADDR_BITS (0xFFFF -> 0x0000 at default).
REQ-024 LED byte SHALL load leds <= din_data[4:0] the following cycle -> DISCARD.
REQ-025 DISCARD SHALL ignore all bytes until frame_end or frame_start.
REQ-026 ml_rdy SHALL be registered: 1 when exec_busy=0 and no exec_start pulse pending/asserted, else 0.
REQ-027 ml_err SHALL remain set until next frame_start or reset.
REQ-028 din_valid outside CMD/ADDR_HI/ADDR_LO/WDATA/LED (i.e. IDLE, DISCARD) SHALL have no effect.

Reset
REQ-029 reset SHALL set state IDLE, address 0, mem_we 0, mem_addr 0, mem_wdata 0, exec_start 0, leds 0, ml_err 0, ml_rdy 0.
REQ-030 ml_rdy SHALL rise the first cycle after reset deasserts if exec_busy=0.
REQ-031 reset mid-frame SHALL abandon the frame; subsequent bytes ignored until next frame_start.

Configuration
REQ-032 Macro MARLANN_LEDCMD_EN defined: command 0x23 behaves per REQ-019/REQ-024.
REQ-033 Macro absent: 0x23 treated as unknown command (ml_err set, DISCARD); leds held at 0.

Verification
REQ-034 frame_start; bytes 21,12,34,AA,BB; frame_end -> mem_we pulses: addr 0x1234 data AA, addr 0x1235 data BB; ml_err 0.
REQ-035 frame; bytes 21,FF,FF,01,02 -> writes addr 0xFFFF=01, 0x0000=02 (wrap).
REQ-036 exec_busy=0; frame; byte 22 -> exec_start single pulse, ml_rdy 0 that cycle; exec_busy=1 then byte 22 in new frame -> no pulse, ml_err 1 until next frame_start.
REQ-037 frame; bytes 21,12; frame_end -> ml_err 1, no mem_we; byte 5A -> ml_err 1, later bytes ignored.
REQ-038 With MARLANN_LEDCMD_EN: bytes 23,1F -> leds 1F; without: ml_err 1, leds 00.
REQ-039 Reset asserted between address and data bytes -> all outputs 0; following data bytes without frame_start produce no mem_we.
